// File: rtl/tally_1d_counter_if.sv
// rtl/tally_1d_counter_if.sv - vector-in / tally-out bundle for tally_1d_counter
interface tally_1d_counter_if #(
  parameter int WIDTH = 12
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] vector;
  logic             in_valid;
  logic [CNT_W-1:0] count;
  logic             out_valid;
  logic             zero;
  logic             all_ones;

  modport master (
    output vector,
    output in_valid,
    input  count,
    input  out_valid,
    input  zero,
    input  all_ones
  );

  modport slave (
    input  vector,
    input  in_valid,
    output count,
    output out_valid,
    output zero,
    output all_ones
  );
endinterface

// File: rtl/tally_1d_counter.sv
// rtl/tally_1d_counter.sv - registered popcount of a packed vector with zero/all-ones flags
module tally_1d_counter #(
  parameter int WIDTH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  tally_1d_counter_if.slave bus
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int LEAVES = 1 << $clog2(WIDTH);

  logic [LEAVES-1:0] vec_pad;
  logic [CNT_W-1:0]  node [1:2*LEAVES-1];
  logic [CNT_W-1:0]  tally;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d;
  logic              all_ones_q, all_ones_d;

  assign vec_pad = LEAVES'(bus.vector);

  // Heap-indexed binary adder tree: leaves at [LEAVES..2*LEAVES-1], root at [1].
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      node[LEAVES+i] = CNT_W'(vec_pad[i]);
    end
    for (int k = LEAVES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k+1];
    end
    tally = node[1];
  end

  // Idle cycles keep the last result so VECTOR is never looked at without IN_VALID.
  always_comb begin
    count_d     = count_q;
    zero_d      = zero_q;
    all_ones_d  = all_ones_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      count_d     = tally;
      zero_d      = (tally == '0);
      all_ones_d  = (tally == CNT_W'(WIDTH));
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      all_ones_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      all_ones_q  <= all_ones_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.out_valid = out_valid_q;
  assign bus.zero      = zero_q;
  assign bus.all_ones  = all_ones_q;
endmodule

// File: tb/tb_tally_1d_counter.sv
// tb/tb_tally_1d_counter.sv - scoreboard bench for tally_1d_counter
module tb_tally_1d_counter;
  localparam int WIDTH = 12;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct {
    int cnt;
    bit zero;
    bit ones;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  tally_1d_counter_if #(.WIDTH(WIDTH)) bus ();

  tally_1d_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tally_model(input logic [WIDTH-1:0] v);
    int n = 0;
    int x = int'(v);
    while (x > 0) begin
      n += x % 2;
      x = x / 2;
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive one edge's worth of inputs; returns shortly after that edge.
  task automatic cycle(input bit rst, input bit valid, input logic [WIDTH-1:0] vec);
    exp_t e;
    @(negedge clk);
    rst_n        = rst;
    bus.in_valid = valid;
    bus.vector   = vec;
    if (rst && valid) begin
      e.cnt  = tally_model(vec);
      e.zero = (e.cnt == 0);
      e.ones = (e.cnt == WIDTH);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every OUT_VALID cycle must match the oldest outstanding accept.
  always @(posedge clk) begin
    #2;
    if (mon_en && bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got out_valid=1 count=%0d, expected no result", bus.count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_count", int'(bus.count), e.cnt);
        check("sb_zero", int'(bus.zero), int'(e.zero));
        check("sb_all_ones", int'(bus.all_ones), int'(e.ones));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] v;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.vector   = 12'hFFF;

    cycle(1'b0, 1'b1, 12'hFFF);
    cycle(1'b0, 1'b1, 12'hFFF);
    check("rst_count", int'(bus.count), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_zero", int'(bus.zero), 0);
    check("rst_all_ones", int'(bus.all_ones), 0);
    mon_en = 1'b1;

    cycle(1'b1, 1'b1, 12'h000);
    check("dir_zero_flag", int'(bus.zero), 1);
    cycle(1'b1, 1'b1, 12'h321);
    check("dir_321", int'(bus.count), 4);
    cycle(1'b1, 1'b1, 12'h8AC);
    check("dir_8ac", int'(bus.count), 5);
    cycle(1'b1, 1'b1, 12'hFFF);
    check("dir_fff", int'(bus.count), 12);
    check("dir_all_ones_flag", int'(bus.all_ones), 1);

    cycle(1'b1, 1'b1, 12'h8AC);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, (i == 1) ? 12'hxxx : 12'hFFF);
      check("hold_count", int'(bus.count), 5);
      check("hold_out_valid", int'(bus.out_valid), 0);
      check("hold_all_ones", int'(bus.all_ones), 0);
    end

    cycle(1'b1, 1'b1, 12'h321);
    cycle(1'b0, 1'b1, 12'hFFF);
    check("midrst_count", int'(bus.count), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    cycle(1'b1, 1'b1, 12'h001);
    check("post_rst_count", int'(bus.count), 1);
    check("post_rst_out_valid", int'(bus.out_valid), 1);

    for (int i = 0; i < WIDTH; i++) begin
      v = '0;
      v[i] = 1'b1;
      cycle(1'b1, 1'b1, v);
      check("walk_count", int'(bus.count), 1);
    end

    for (int i = 0; i < 1000; i++) begin
      v = WIDTH'($urandom_range(0, 12'hFFF));
      cycle(1'b1, 1'($urandom_range(0, 1)), v);
    end

    cycle(1'b1, 1'b0, 12'h000);
    cycle(1'b1, 1'b0, 12'h000);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
